// File: rtl/fifo2axis_framer_if.sv
// AXI-Stream bus carrying fixed-length frames from the framer to its consumer.
//   tdata  : stream payload word
//   tvalid : beat valid (source)
//   tready : beat accepted (sink)
//   tlast  : final beat of a frame
// master modport is the framer side; slave modport is the consumer side.
interface fifo2axis_framer_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fifo2axis_framer.sv
// fifo2axis_framer: drains a synchronous FIFO (1-cycle read latency) and emits
// fixed FRAME_LEN-beat AXI-Stream frames. A frame is only started when the whole
// frame is already buffered, so the consumer sees contiguous frames.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : allows a new frame to start (looked at in IDLE only)
//   fifo_dout      : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty     : FIFO empty flag
//   fifo_count     : words held in the FIFO
//   fifo_rd_en     : FIFO read strobe (combinational from state)
//   m_axis         : AXI-Stream master (tdata/tvalid/tready/tlast)
//   frame_done     : one-cycle pulse after the last beat handshakes
//   frame_count    : completed frames, wraps
//   underflow      : sticky, FIFO ran dry in the middle of a frame
module fifo2axis_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 4,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic [CNT_W-1:0]      fifo_count,
    output logic                  fifo_rd_en,
    fifo2axis_framer_if.master    m_axis,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  underflow
);
    // Beat counter is at least one bit wide so FRAME_LEN=1 still elaborates.
    localparam int              BW          = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BW-1:0]   LAST_BEAT   = BW'(FRAME_LEN - 1);
    localparam logic [CNT_W:0]  FRAME_WORDS = (CNT_W + 1)'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, SEND} state_t;

    state_t                state, state_nxt;
    logic [BW-1:0]         beat_cnt;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  handshake;

    assign handshake     = tvalid_q && m_axis.tready;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and read strobe. A mid-frame read is issued in the same cycle
    // as the handshake so the next word lands in CAPTURE one cycle later.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (enable && ({1'b0, fifo_count} >= FRAME_WORDS)) state_nxt = FETCH;
            end
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = CAPTURE;
                end
            end
            CAPTURE: state_nxt = SEND;
            SEND: begin
                if (handshake) begin
                    if (tlast_q) begin
                        state_nxt = IDLE;
                    end else if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        state_nxt  = CAPTURE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and status. tdata is left untouched when tvalid drops so it never
    // goes unknown between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            underflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                FETCH: begin
                    // Starved after the frame already began.
                    if (fifo_empty && (beat_cnt != '0)) underflow <= 1'b1;
                end
                CAPTURE: begin
                    tdata_q  <= fifo_dout;
                    tvalid_q <= 1'b1;
                    tlast_q  <= (beat_cnt == LAST_BEAT);
                end
                SEND: begin
                    if (handshake) begin
                        tvalid_q <= 1'b0;
                        if (tlast_q) begin
                            tlast_q     <= 1'b0;
                            beat_cnt    <= '0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (fifo_empty) underflow <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo2axis_framer.sv
// Directed bench for fifo2axis_framer with a behavioural 1-cycle-latency FIFO.
module tb_fifo2axis_framer;
    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic        fifo_rd_en;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        underflow;

    fifo2axis_framer_if #(.DATA_WIDTH(32)) m_axis ();

    fifo2axis_framer #(.DATA_WIDTH(32), .FRAME_LEN(4), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .fifo_rd_en (fifo_rd_en),
        .m_axis     (m_axis),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIFO model: words pushed at negedge, popped at posedge on fifo_rd_en.
    logic [31:0] q[$];
    int          fcnt = 0;
    logic        force_en = 1'b0;
    logic [4:0]  force_val = 5'd0;

    assign fifo_empty = (fcnt == 0);
    assign fifo_count = force_en ? force_val : 5'(fcnt);

    initial fifo_dout = 32'h0;
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            chk("rd_en while empty", {63'h0, fifo_empty}, 64'h0);
            if (q.size() > 0) fifo_dout <= q.pop_front();
            fcnt <= q.size();
        end
    end

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        fcnt <= q.size();
        @(negedge clk);
    endtask

    // Monitor: pre-edge values at posedge are the ones the DUT acts on.
    logic [32:0] beats[$];
    int          rd_cnt = 0;
    int          fd_cnt = 0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) rd_cnt++;
            if (frame_done) fd_cnt++;
            if (m_axis.tvalid && m_axis.tready) beats.push_back({m_axis.tlast, m_axis.tdata});
        end
    end

    task automatic clr();
        beats.delete();
        rd_cnt = 0;
        fd_cnt = 0;
    endtask

    task automatic wait_fd(input int target, input string tag);
        int n = 0;
        while (fd_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " timeout"}, 64'(fd_cnt >= target), 64'd1);
    endtask

    function automatic logic [32:0] beat_at(input int i);
        return (i < beats.size()) ? beats[i] : 33'h0;
    endfunction

    initial begin
        logic [3:0]  pat;
        logic        prev_v, prev_r, prev_l;
        logic [31:0] prev_d;
        int          stalls;
        int          n;

        rst_n         = 1'b0;
        enable        = 1'b0;
        m_axis.tready = 1'b1;
        pat           = 4'b1001;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst tvalid", {63'h0, m_axis.tvalid}, 64'h0);
        chk("rst tlast", {63'h0, m_axis.tlast}, 64'h0);
        chk("rst tdata", 64'(m_axis.tdata), 64'h0);
        chk("rst frame_done", {63'h0, frame_done}, 64'h0);
        chk("rst frame_count", 64'(frame_count), 64'h0);
        chk("rst underflow", {63'h0, underflow}, 64'h0);
        chk("rst rd_en", {63'h0, fifo_rd_en}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: preloaded frame, latency and order
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        clr();
        enable = 1'b1;
        @(negedge clk);
        chk("t1 tvalid fetch", {63'h0, m_axis.tvalid}, 64'h0);
        @(negedge clk);
        chk("t1 tvalid capture", {63'h0, m_axis.tvalid}, 64'h0);
        @(negedge clk);
        chk("t1 first tvalid", {63'h0, m_axis.tvalid}, 64'h1);
        chk("t1 first tdata", 64'(m_axis.tdata), 64'h11);
        wait_fd(1, "t1");
        repeat (3) @(negedge clk);
        chk("t1 beats", 64'(beats.size()), 64'd4);
        chk("t1 beat0", 64'(beat_at(0)), {31'h0, 1'b0, 32'h11});
        chk("t1 beat1", 64'(beat_at(1)), {31'h0, 1'b0, 32'h22});
        chk("t1 beat2", 64'(beat_at(2)), {31'h0, 1'b0, 32'h33});
        chk("t1 beat3", 64'(beat_at(3)), {31'h0, 1'b1, 32'h44});
        chk("t1 frame_done pulses", 64'(fd_cnt), 64'd1);
        chk("t1 frame_count", 64'(frame_count), 64'd1);
        chk("t1 rd_en pulses", 64'(rd_cnt), 64'd4);
        chk("t1 underflow", {63'h0, underflow}, 64'h0);

        // 2: three words are not enough to start
        clr();
        push(32'hB0); push(32'hB1); push(32'hB2);
        n = 0;
        repeat (20) begin
            if (m_axis.tvalid) n++;
            @(negedge clk);
        end
        chk("t2 no rd_en", 64'(rd_cnt), 64'd0);
        chk("t2 no tvalid", 64'(n), 64'd0);
        push(32'hB3);
        chk("t2 start rd_en", {63'h0, fifo_rd_en}, 64'h1);
        wait_fd(1, "t2");
        chk("t2 beat0", 64'(beat_at(0)), {31'h0, 1'b0, 32'hB0});
        chk("t2 beat3", 64'(beat_at(3)), {31'h0, 1'b1, 32'hB3});
        chk("t2 frame_count", 64'(frame_count), 64'd2);

        // 3: backpressure 1,0,0,1
        clr();
        push(32'hA0); push(32'hA1); push(32'hA2); push(32'hA3);
        stalls = 0; n = 0;
        prev_v = 1'b0; prev_r = 1'b1; prev_l = 1'b0; prev_d = 32'h0;
        while (fd_cnt < 1 && n < 100) begin
            if (prev_v && !prev_r) begin
                stalls++;
                chk("t3 stall tvalid", {63'h0, m_axis.tvalid}, 64'h1);
                chk("t3 stall tdata", 64'(m_axis.tdata), 64'(prev_d));
                chk("t3 stall tlast", {63'h0, m_axis.tlast}, {63'h0, prev_l});
            end
            prev_v = m_axis.tvalid;
            prev_d = m_axis.tdata;
            prev_l = m_axis.tlast;
            prev_r = pat[n % 4];
            m_axis.tready = prev_r;
            @(negedge clk);
            n++;
        end
        m_axis.tready = 1'b1;
        chk("t3 done", 64'(fd_cnt), 64'd1);
        chk("t3 stalls seen", 64'(stalls > 0), 64'd1);
        chk("t3 beats", 64'(beats.size()), 64'd4);
        chk("t3 beat0", 64'(beat_at(0)), {31'h0, 1'b0, 32'hA0});
        chk("t3 beat1", 64'(beat_at(1)), {31'h0, 1'b0, 32'hA1});
        chk("t3 beat2", 64'(beat_at(2)), {31'h0, 1'b0, 32'hA2});
        chk("t3 beat3", 64'(beat_at(3)), {31'h0, 1'b1, 32'hA3});
        chk("t3 frame_count", 64'(frame_count), 64'd3);

        // 4: underflow with count forced to 4
        clr();
        enable = 1'b0;
        push(32'hC0); push(32'hC1);
        force_val = 5'd4;
        force_en  = 1'b1;
        enable    = 1'b1;
        repeat (15) @(negedge clk);
        chk("t4 beats before starve", 64'(beats.size()), 64'd2);
        chk("t4 underflow", {63'h0, underflow}, 64'h1);
        chk("t4 tvalid starved", {63'h0, m_axis.tvalid}, 64'h0);
        push(32'hC2);
        force_en = 1'b0;
        push(32'hC3);
        wait_fd(1, "t4");
        chk("t4 beats", 64'(beats.size()), 64'd4);
        chk("t4 beat2", 64'(beat_at(2)), {31'h0, 1'b0, 32'hC2});
        chk("t4 beat3", 64'(beat_at(3)), {31'h0, 1'b1, 32'hC3});
        chk("t4 underflow sticky", {63'h0, underflow}, 64'h1);
        chk("t4 frame_count", 64'(frame_count), 64'd4);

        // 5: two back-to-back frames
        clr();
        enable = 1'b0;
        for (int i = 0; i < 8; i++) push(32'hD0 + 32'(i));
        enable = 1'b1;
        wait_fd(2, "t5");
        repeat (3) @(negedge clk);
        chk("t5 beats", 64'(beats.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t5 beat%0d", i), 64'(beat_at(i)),
                {31'h0, (i == 3 || i == 7), 32'hD0 + 32'(i)});
        chk("t5 rd_en pulses", 64'(rd_cnt), 64'd8);
        chk("t5 frame_count", 64'(frame_count), 64'd6);

        // 6: reset mid-frame, then a clean frame
        clr();
        enable = 1'b0;
        push(32'hE0); push(32'hE1); push(32'hE2); push(32'hE3);
        enable = 1'b1;
        n = 0;
        while (!(beats.size() == 2 && m_axis.tvalid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6 reached beat2", 64'(n < 100), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6 rst tvalid", {63'h0, m_axis.tvalid}, 64'h0);
        chk("t6 rst tlast", {63'h0, m_axis.tlast}, 64'h0);
        chk("t6 rst frame_count", 64'(frame_count), 64'h0);
        chk("t6 rst underflow", {63'h0, underflow}, 64'h0);
        chk("t6 rst rd_en", {63'h0, fifo_rd_en}, 64'h0);
        q.delete();
        fcnt <= 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr();
        @(negedge clk);
        push(32'hF0); push(32'hF1); push(32'hF2); push(32'hF3);
        wait_fd(1, "t6");
        chk("t6 beats", 64'(beats.size()), 64'd4);
        chk("t6 beat0", 64'(beat_at(0)), {31'h0, 1'b0, 32'hF0});
        chk("t6 beat3", 64'(beat_at(3)), {31'h0, 1'b1, 32'hF3});
        chk("t6 frame_count", 64'(frame_count), 64'd1);
        chk("t6 underflow", {63'h0, underflow}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo2axis_framer.md
Name: fifo2axis_framer

Overview:
- Upstream stage of the stream-to-FIFO capture path.
- Drains words from a synchronous FIFO (1-cycle read latency) and emits them as fixed-length AXI-Stream frames.
- Frames are FRAME_LEN beats, with tvalid/tready handshake and tlast on the final beat.
- A frame starts only when the whole frame is already in the FIFO, so the downstream consumer sees contiguous frames.

Parameters:
DATA_WIDTH, 32, width of FIFO words and m_axis_tdata
FRAME_LEN, 4, beats per frame (>=1); matches the downstream buffer threshold
CNT_W, 5, width of fifo_count input

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits starting a new frame; sampled in IDLE only
fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
fifo_empty  input  1  FIFO empty flag
fifo_count  input  CNT_W  words currently held in FIFO
fifo_rd_en  output  1  FIFO read strobe (combinational from state, registered inputs)
m_axis_tdata  output  DATA_WIDTH  stream data
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready from downstream
m_axis_tlast  output  1  high on beat FRAME_LEN-1 of each frame
frame_done  output  1  one-cycle pulse the cycle after the last beat handshakes
frame_count  output  16  frames completed, wraps 0xFFFF->0
underflow  output  1  sticky: FIFO was empty when a mid-frame read was needed

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat_cnt=0.
  - Outputs at reset: tdata=0, tvalid=0, tlast=0, frame_done=0, frame_count=0, underflow=0.
  - fifo_rd_en=0 during reset.
- Handshake: a beat transfers when tvalid && tready.
  - While tvalid=1 && tready=0, tdata and tlast hold unchanged.
  - tvalid never deasserts without a handshake.
- fifo_rd_en = (state==FETCH && !fifo_empty) || (state==SEND && handshake && !tlast && !fifo_empty).
  - fifo_rd_en is never asserted while fifo_empty=1.
- States:
  - IDLE: if enable && fifo_count>=FRAME_LEN -> FETCH; else stay.
  - FETCH:
    - If !fifo_empty: read issued -> CAPTURE.
    - If fifo_empty: set underflow=1 when beat_cnt!=0, and stay in FETCH.
  - CAPTURE:
    - tdata<=fifo_dout, tvalid<=1, tlast<=(beat_cnt==FRAME_LEN-1).
    - Next state is SEND.
  - SEND, on handshake with tlast=1:
    - tvalid<=0, tlast<=0, beat_cnt<=0.
    - frame_done<=1 next cycle; frame_count<=frame_count+1.
    - Next state is IDLE.
  - SEND, on handshake with tlast=0:
    - beat_cnt<=beat_cnt+1, tvalid<=0.
    - If !fifo_empty: read issued, next state is CAPTURE.
    - Else: next state is FETCH and underflow<=1.
  - SEND, no handshake: hold.
- Latency:
  - IDLE qualifying -> first tvalid: 2 cycles (FETCH, CAPTURE).
  - Sustained throughput with tready=1: 1 beat per 2 cycles.
  - Minimum frame time: 2*FRAME_LEN cycles plus return to IDLE.
- frame_done is a single-cycle pulse, 0 otherwise.
  - A new frame may start in the IDLE cycle that frame_done is high.
- enable deasserted mid-frame: ignored; the frame completes.
- fifo_count dropping below FRAME_LEN mid-frame: ignored; only fifo_empty gates reads.
- FRAME_LEN=1: every beat has tlast=1.
- Reset mid-frame: frame abandoned immediately, all outputs to reset values, no partial tlast emitted.
- tdata retains its last value when tvalid=0 (not X).

Test Plan:
- FIFO preloaded 0x11,0x22,0x33,0x44, enable=1, tready=1:
  - Beats 0x11..0x44 appear with tlast only on 0x44.
  - First tvalid 2 cycles after IDLE exit.
  - frame_done pulses once; frame_count=1; exactly 4 fifo_rd_en pulses.
- fifo_count=3, enable=1: no fifo_rd_en and tvalid=0 for 20 cycles. Push a 4th word: frame starts within 2 cycles.
- tready toggled 1,0,0,1 pattern during frame 0xA0..0xA3: tdata/tlast stable on stalled cycles; data order and single tlast preserved.
- FIFO holds 2 words but fifo_count is forced to 4:
  - After 2 beats, the FSM waits in FETCH and underflow=1.
  - Push 2 more words: the frame completes with tlast and underflow stays 1.
- 8 words preloaded, enable=1: two back-to-back frames, frame_count=2, tlast on beats 4 and 8 only.
- Assert rst_n=0 during beat 2 of a frame:
  - tvalid/tlast/frame_count/underflow immediately 0.
  - After release with 4 new words, a clean frame is emitted.
